// File: rtl/i2s_dac_tx_if.sv
// Sample handshake between the upstream IIR stage and the I2S transmitter.
interface i2s_dac_tx_if #(
  parameter int DATA_W = 16
);
  logic              i_valid;
  logic [DATA_W-1:0] i_left;
  logic [DATA_W-1:0] i_right;
  logic              o_ready;

  modport master (output i_valid, output i_left, output i_right, input o_ready);
  modport slave  (input i_valid, input i_left, input i_right, output o_ready);
endinterface

// File: rtl/i2s_dac_tx.sv
// I2S DAC transmitter: slave to codec BCLK/LRCLK, one-pair holding buffer,
// MSB-first serialization with the standard one-BCLK I2S delay after each LRCLK edge.
module i2s_dac_tx #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_bclk,
  input  logic          i_lrclk,
  i2s_dac_tx_if.slave   s_if,
  output logic          o_dacdat,
  output logic          lrclk_negedge,
  output logic          lrclk_posedge,
  output logic          o_underrun
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_MSB,
    ST_SHIFT,
    ST_PAD
  } state_t;

  // Synchronizers and edge detect
  logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
  logic [SYNC_STAGES-1:0] lr_sync_q, lr_sync_d;
  logic                   bclk_dly_q, bclk_dly_d;
  logic                   lr_dly_q, lr_dly_d;
  logic                   bclk_fall, lr_fall, lr_rise;

  // Holding buffer and frame registers
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [DATA_W-1:0] frame_l_q, frame_l_d, frame_r_q, frame_r_d;
  logic              underrun_q, underrun_d;
  logic              accept;

  // Serializer
  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              dacdat_q, dacdat_d;

  // Shift async clocks into clk domain; both chains have identical depth so an
  // LRCLK edge and its coincident BCLK fall are seen in the same cycle.
  always_comb begin
    bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], i_bclk};
    lr_sync_d   = {lr_sync_q[SYNC_STAGES-2:0], i_lrclk};
    bclk_dly_d  = bclk_sync_q[SYNC_STAGES-1];
    lr_dly_d    = lr_sync_q[SYNC_STAGES-1];
    bclk_fall   = bclk_dly_q & ~bclk_sync_q[SYNC_STAGES-1];
    lr_fall     = lr_dly_q & ~lr_sync_q[SYNC_STAGES-1];
    lr_rise     = ~lr_dly_q & lr_sync_q[SYNC_STAGES-1];
  end

  // Holding buffer: accept one pair, hand it to the frame registers on left-frame start.
  // Accepting is only possible while empty, so an accept coincident with lr_fall
  // lands in holding while the frame takes zeros.
  always_comb begin
    accept      = s_if.i_valid & ~hold_full_q;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    frame_l_d   = frame_l_q;
    frame_r_d   = frame_r_q;
    underrun_d  = 1'b0;
    if (lr_fall) begin
      if (hold_full_q) begin
        frame_l_d   = hold_l_q;
        frame_r_d   = hold_r_q;
        hold_full_d = 1'b0;
      end else begin
        frame_l_d   = '0;
        frame_r_d   = '0;
        underrun_d  = 1'b1;
      end
    end
    if (accept) begin
      hold_full_d = 1'b1;
      hold_l_d    = s_if.i_left;
      hold_r_d    = s_if.i_right;
    end
  end

  // Slot serializer: an LR edge reloads the shifter (the coincident BCLK fall is
  // slot bit -1 and leaves DACDAT alone); later BCLK falls emit MSB..LSB then zeros.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    dacdat_d  = dacdat_q;
    if (lr_fall || (lr_rise && state_q != ST_IDLE)) begin
      state_d   = ST_WAIT_MSB;
      shift_d   = lr_fall ? frame_l_d : frame_r_q;
      bit_cnt_d = '0;
    end else if (bclk_fall) begin
      case (state_q)
        ST_WAIT_MSB, ST_SHIFT: begin
          dacdat_d  = shift_q[DATA_W-1];
          shift_d   = {shift_q[DATA_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          state_d   = (bit_cnt_q + CNT_W'(1) == LAST_BIT) ? ST_PAD : ST_SHIFT;
        end
        ST_PAD:  dacdat_d = 1'b0;
        default: state_d  = ST_IDLE;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      bclk_sync_q <= '0;
      lr_sync_q   <= '0;
      bclk_dly_q  <= 1'b0;
      lr_dly_q    <= 1'b0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      frame_l_q   <= '0;
      frame_r_q   <= '0;
      underrun_q  <= 1'b0;
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      dacdat_q    <= 1'b0;
    end else begin
      bclk_sync_q <= bclk_sync_d;
      lr_sync_q   <= lr_sync_d;
      bclk_dly_q  <= bclk_dly_d;
      lr_dly_q    <= lr_dly_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      frame_l_q   <= frame_l_d;
      frame_r_q   <= frame_r_d;
      underrun_q  <= underrun_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      dacdat_q    <= dacdat_d;
    end
  end

  assign s_if.o_ready  = ~hold_full_q;
  assign o_dacdat      = dacdat_q;
  assign lrclk_negedge = lr_fall;
  assign lrclk_posedge = lr_rise;
  assign o_underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: drives codec-style BCLK/LRCLK, samples DACDAT once per BCLK
// period like a codec would, and compares whole slots against a word-level model.
module tb_i2s_dac_tx;

  logic clk, rst, bclk, lrclk;
  logic o_dacdat, lrclk_negedge, lrclk_posedge, o_underrun;

  i2s_dac_tx_if #(.DATA_W(16)) bus ();

  i2s_dac_tx #(.DATA_W(16), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .i_rst         (rst),
    .i_bclk        (bclk),
    .i_lrclk       (lrclk),
    .s_if          (bus),
    .o_dacdat      (o_dacdat),
    .lrclk_negedge (lrclk_negedge),
    .lrclk_posedge (lrclk_posedge),
    .o_underrun    (o_underrun)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  logic        m_hold_valid = 1'b0;
  logic [15:0] m_hold_l = '0, m_hold_r = '0;
  logic [15:0] m_frame_l = '0, m_frame_r = '0;
  logic        m_idle = 1'b1;
  logic        m_prev = 1'b0;
  logic [31:0] tx_q[$];
  logic [31:0] push_q[$];
  int cnt_under = 0, cnt_neg = 0, cnt_pos = 0;
  logic prev_rdy = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic exp_bit(input logic [15:0] w, input int j);
    if (j >= 1 && j <= 16) return w[16-j];
    return 1'b0;
  endfunction

  // Pulse counters sampled mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (o_underrun)    cnt_under++;
      if (lrclk_negedge) cnt_neg++;
      if (lrclk_posedge) cnt_pos++;
    end
  end

  // Upstream source: keeps i_valid high while pairs are queued; an accept is the
  // posedge where valid was high and ready (stable since last negedge) was high.
  initial begin
    bus.i_valid = 1'b0;
    bus.i_left  = '0;
    bus.i_right = '0;
    forever begin
      @(negedge clk);
      if (bus.i_valid && prev_rdy) begin
        m_hold_valid = 1'b1;
        m_hold_l     = bus.i_left;
        m_hold_r     = bus.i_right;
        chk("ready_after_accept", {31'd0, bus.o_ready}, 32'd0);
        bus.i_valid = 1'b0;
      end
      if (!bus.i_valid && tx_q.size() > 0) begin
        logic [31:0] p;
        p = tx_q.pop_front();
        bus.i_valid = 1'b1;
        bus.i_left  = p[31:16];
        bus.i_right = p[15:0];
      end
      prev_rdy = bus.o_ready;
    end
  end

  // One LRCLK frame of two slots of slen BCLKs; rst_at >= 0 pulses reset at that left-slot bit.
  task automatic run_frame(input int slen, input int rst_at);
    logic [31:0] obs, expv;
    logic        e;
    int u0, n0, p0;
    logic exp_under;
    u0 = cnt_under; n0 = cnt_neg; p0 = cnt_pos;
    exp_under = 1'b0;
    for (int s = 0; s < 2; s++) begin
      obs = '0; expv = '0;
      for (int j = 0; j < slen; j++) begin
        bclk = 1'b0;
        if (j == 0) lrclk = (s == 1);
        #1;
        if (s == 0 && j == 0) begin
          m_idle = 1'b0;
          if (m_hold_valid) begin
            m_frame_l = m_hold_l; m_frame_r = m_hold_r;
            m_hold_valid = 1'b0; exp_under = 1'b0;
          end else begin
            m_frame_l = '0; m_frame_r = '0; exp_under = 1'b1;
          end
        end
        if (s == 0 && j == 4)
          while (push_q.size() > 0) tx_q.push_back(push_q.pop_front());
        #79;
        bclk = 1'b1;
        if (s == 0 && j == rst_at) begin
          rst = 1'b1;
          #1;
          chk("reset_dacdat", {31'd0, o_dacdat}, 32'd0);
          chk("reset_ready", {31'd0, bus.o_ready}, 32'd1);
          m_idle = 1'b1; m_hold_valid = 1'b0; m_prev = 1'b0;
          m_frame_l = '0; m_frame_r = '0;
          #19;
          rst = 1'b0;
          #20;
        end else begin
          #40;
        end
        #39;
        if (m_idle)      e = 1'b0;
        else if (j == 0) e = m_prev;
        else             e = exp_bit((s == 0) ? m_frame_l : m_frame_r, j);
        obs[j]  = o_dacdat;
        expv[j] = e;
        m_prev  = e;
        if ((s == 0 && j == 2) || (s == 1 && j == slen - 1))
          chk("ready_level", {31'd0, bus.o_ready}, {31'd0, !m_hold_valid});
        #1;
      end
      chk((s == 0) ? "left_slot_bits" : "right_slot_bits", obs, expv);
    end
    chk("underrun_pulses", cnt_under - u0, {31'd0, exp_under});
    chk("lr_negedge_pulses", cnt_neg - n0, 32'd1);
    chk("lr_posedge_pulses", cnt_pos - p0, 32'd1);
  endtask

  initial begin
    logic [31:0] p1, p2, p3;
    rst = 1'b1; bclk = 1'b1; lrclk = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dacdat", {31'd0, o_dacdat}, 32'd0);
    chk("rst_ready", {31'd0, bus.o_ready}, 32'd1);
    chk("rst_negedge", {31'd0, lrclk_negedge}, 32'd0);
    chk("rst_posedge", {31'd0, lrclk_posedge}, 32'd0);
    chk("rst_underrun", {31'd0, o_underrun}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Idle stream: zeros and an underrun every frame
    run_frame(32, -1);
    run_frame(32, -1);
    // Directed pair
    push_q.push_back({16'h8001, 16'h7FFE});
    run_frame(32, -1);
    // Back-to-back random pairs with valid held high
    p1 = $urandom; p2 = $urandom; p3 = $urandom;
    push_q.push_back(p1); push_q.push_back(p2); push_q.push_back(p3);
    run_frame(32, -1);
    run_frame(32, -1);
    run_frame(32, -1);
    run_frame(32, -1);
    // Skipped pair: zero frame, then resume
    push_q.push_back($urandom);
    run_frame(32, -1);
    push_q.push_back({16'hFFFF, 16'($urandom)});
    run_frame(32, -1);
    // Reset in the middle of an all-ones left slot
    run_frame(32, 8);
    // Short 16-BCLK slots truncate the LSB
    push_q.push_back({16'hFFFF, 16'($urandom)});
    run_frame(32, -1);
    push_q.push_back($urandom);
    run_frame(16, -1);
    push_q.push_back($urandom);
    run_frame(16, -1);
    run_frame(32, -1);
    run_frame(32, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
